mem_ctrl: RTL and testbench

Byte-bus initiator inside the CPU. It converts word-level requests from the instruction-fetch unit and the load/store buffer into the one-byte-per-cycle memory bus that the top level decodes into RAM or HCI I/O. It reads over `mem_a`/`mem_din` and writes over `mem_a`/`mem_dout`/`mem_wr`. It honours `rdy_in` (HCI debug pause) and `io_buffer_full` (UART TX back-pressure).

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-bus memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // Address bits [17:16] select between RAM and the HCI I/O window.
    function automatic logic in_io_region(input logic [1:0] addr_hi, input logic [1:0] io_hi);
        return addr_hi == io_hi;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-bus initiator: turns word-level fetch and load/store requests into
// one byte per cycle on mem_a/mem_din/mem_dout/mem_wr.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | bus quiet, waiting for a request (load/store wins over fetch)
// ST_READ  | issuing addresses and capturing bytes, one cycle behind
// ST_WRITE | driving one byte per cycle, stalling on a full I/O buffer
// ST_DONE  | one-cycle done pulse; the other requester may be accepted
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  issued_q, issued_d;
    logic [2:0]  captured_q, captured_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        accept_ls, accept_if;
    logic [31:0] accept_addr;
    logic [31:0] issue_addr;
    logic [4:0]  cap_lsb, iss_lsb;

    // The requester that just finished is masked in ST_DONE so a held valid
    // is not taken twice, while the other requester can start right away.
    assign accept_ls   = ls_valid && !(state_q == ST_DONE && owner_q == OWN_LS);
    assign accept_if   = if_valid && !(state_q == ST_DONE && owner_q == OWN_IF);
    assign accept_addr = accept_ls ? ls_addr : if_addr;
    assign issue_addr  = base_q + {29'd0, issued_q};
    assign cap_lsb     = {captured_q[1:0], 3'b000};
    assign iss_lsb     = {issued_q[1:0], 3'b000};

    // Next-state, counters and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        base_d     = base_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        issued_d   = issued_q;
        captured_d = captured_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        if_data_d  = if_data_q;
        ls_done_d  = ls_done_q;
        ls_rdata_d = ls_rdata_q;

        if (!rdy_in) begin
            // Frozen: the byte in flight is dropped and re-issued later.
            mem_wr_d = 1'b0;
            if (state_q == ST_READ) begin
                issued_d = captured_q;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d    = ST_IDLE;
                    mem_a_d    = 32'd0;
                    mem_dout_d = 8'd0;
                    mem_wr_d   = 1'b0;
                    if_done_d  = 1'b0;
                    if_data_d  = 32'd0;
                    ls_done_d  = 1'b0;
                    ls_rdata_d = 32'd0;
                    if (accept_ls || accept_if) begin
                        owner_d    = accept_ls ? OWN_LS : OWN_IF;
                        base_d     = accept_addr;
                        len_d      = accept_ls ? ls_len : LEN_WORD;
                        wdata_d    = ls_wdata;
                        issued_d   = 3'd0;
                        captured_d = 3'd0;
                        buf_d      = 32'd0;
                        if (accept_ls && ls_wr) begin
                            state_d = ST_WRITE;
                            if (!(in_io_region(accept_addr[17:16], IO_BASE_HI) && io_buffer_full)) begin
                                mem_a_d    = accept_addr;
                                mem_dout_d = ls_wdata[7:0];
                                mem_wr_d   = 1'b1;
                                issued_d   = 3'd1;
                            end
                        end else begin
                            state_d  = ST_READ;
                            mem_a_d  = accept_addr;
                            issued_d = 3'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (issued_q > captured_q) begin
                        buf_d[cap_lsb +: 8] = mem_din;
                        captured_d          = captured_q + 3'd1;
                    end
                    if (issued_q < len_q) begin
                        mem_a_d  = issue_addr;
                        issued_d = issued_q + 3'd1;
                    end else begin
                        mem_a_d = 32'd0;
                    end
                    if (captured_d == len_q) begin
                        state_d = ST_DONE;
                        if (owner_q == OWN_LS) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = buf_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = buf_d;
                        end
                    end
                end
                ST_WRITE: begin
                    if (issued_q < len_q) begin
                        if (in_io_region(issue_addr[17:16], IO_BASE_HI) && io_buffer_full) begin
                            mem_a_d  = 32'd0;
                            mem_wr_d = 1'b0;
                        end else begin
                            mem_a_d    = issue_addr;
                            mem_dout_d = wdata_q[iss_lsb +: 8];
                            mem_wr_d   = 1'b1;
                            issued_d   = issued_q + 3'd1;
                        end
                    end else begin
                        state_d    = ST_DONE;
                        mem_a_d    = 32'd0;
                        mem_dout_d = 8'd0;
                        mem_wr_d   = 1'b0;
                        if (owner_q == OWN_LS) begin
                            ls_done_d = 1'b1;
                        end else begin
                            if_done_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            base_q     <= 32'd0;
            len_q      <= 3'd0;
            wdata_q    <= 32'd0;
            issued_q   <= 3'd0;
            captured_q <= 3'd0;
            buf_q      <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            base_q     <= base_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            issued_q   <= issued_d;
            captured_q <= captured_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fixed RAM image, logged bus writes.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_valid;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_len;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int n_cmp = 0;
    int n_err = 0;

    int          wr_count;
    logic [31:0] last_wa;
    logic [7:0]  last_wd;
    logic [7:0]  wlog [0:3];

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_valid       (if_valid),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_valid       (ls_valid),
        .ls_wr          (ls_wr),
        .ls_addr        (ls_addr),
        .ls_len         (ls_len),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1001: return 8'h05;
            32'h0000_1002: return 8'h00;
            32'h0000_1003: return 8'h00;
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'h0000_2002: return 8'hFF;
            32'h0000_2003: return 8'h80;
            default:       return 8'hA5;
        endcase
    endfunction

    assign mem_din = rom_byte(mem_a);

    initial begin
        wr_count = 0;
        last_wa  = 32'd0;
        last_wd  = 8'd0;
        for (int i = 0; i < 4; i++) wlog[i] = 8'h00;
    end

    always @(posedge clk_in) begin
        if (mem_wr) begin
            wr_count <= wr_count + 1;
            last_wa  <= mem_a;
            last_wd  <= mem_dout;
            if (mem_a[31:2] == 30'h800) wlog[mem_a[1:0]] <= mem_dout;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2000; ls_len = LEN_WORD; ls_wdata = 32'h12345678;
        step(); step();
        n_cmp++; if (mem_a !== 32'd0)    begin n_err++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_cmp++; if (mem_wr !== 1'b0)    begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (mem_dout !== 8'd0)  begin n_err++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        n_cmp++; if (if_done !== 1'b0)   begin n_err++; $display("FAIL reset_if_done: got %b want 0", if_done); end
        n_cmp++; if (ls_done !== 1'b0)   begin n_err++; $display("FAIL reset_ls_done: got %b want 0", ls_done); end
        n_cmp++; if (if_data !== 32'd0)  begin n_err++; $display("FAIL reset_if_data: got %h want 0", if_data); end
        n_cmp++; if (ls_rdata !== 32'd0) begin n_err++; $display("FAIL reset_ls_rdata: got %h want 0", ls_rdata); end
        ls_valid = 1'b0;
        rst_in = 1'b0;
        step();
        n_cmp++; if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL idle_quiet: got a=%h wr=%b want 0/0", mem_a, mem_wr); end
    endtask

    task automatic test_fetch();
        if_valid = 1'b1; if_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (mem_a !== 32'h1000 + k) begin n_err++; $display("FAIL fetch_addr k=%0d: got %h want %h", k, mem_a, 32'h1000 + k); end
            n_cmp++; if (if_done !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL fetch_early k=%0d: got done=%b wr=%b want 0/0", k, if_done, mem_wr); end
        end
        step();
        n_cmp++; if (if_done !== 1'b1)         begin n_err++; $display("FAIL fetch_done: got %b want 1", if_done); end
        n_cmp++; if (if_data !== 32'h00000513) begin n_err++; $display("FAIL fetch_data: got %h want 00000513", if_data); end
        n_cmp++; if (mem_a !== 32'd0)          begin n_err++; $display("FAIL fetch_bus_idle: got %h want 0", mem_a); end
        if_valid = 1'b0;
        step();
        n_cmp++; if (if_done !== 1'b0 || if_data !== 32'd0) begin n_err++; $display("FAIL fetch_pulse: got done=%b data=%h want 0/0", if_done, if_data); end
        step();
        n_cmp++; if (mem_a !== 32'd0) begin n_err++; $display("FAIL fetch_no_reaccept: got %h want 0", mem_a); end
    endtask

    task automatic test_load_half();
        ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2002; ls_len = LEN_HALF;
        step();
        n_cmp++; if (mem_a !== 32'h2002) begin n_err++; $display("FAIL half_addr0: got %h want 2002", mem_a); end
        step();
        n_cmp++; if (mem_a !== 32'h2003) begin n_err++; $display("FAIL half_addr1: got %h want 2003", mem_a); end
        step();
        n_cmp++; if (ls_done !== 1'b1)         begin n_err++; $display("FAIL half_done: got %b want 1", ls_done); end
        n_cmp++; if (ls_rdata !== 32'h000080FF) begin n_err++; $display("FAIL half_data: got %h want 000080ff", ls_rdata); end
        ls_valid = 1'b0;
        step();
        n_cmp++; if (ls_done !== 1'b0) begin n_err++; $display("FAIL half_pulse: got %b want 0", ls_done); end
    endtask

    task automatic test_priority();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2000; ls_len = LEN_WORD; ls_wdata = 32'hDEADBEEF;
        if_valid = 1'b1; if_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (mem_a !== 32'h2000 + k || mem_wr !== 1'b1 || mem_dout !== exp_b[k]) begin
                n_err++; $display("FAIL prio_store k=%0d: got a=%h wr=%b d=%h want a=%h wr=1 d=%h", k, mem_a, mem_wr, mem_dout, 32'h2000 + k, exp_b[k]);
            end
        end
        step();
        n_cmp++; if (ls_done !== 1'b1 || if_done !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL prio_ls_done: got ls=%b if=%b wr=%b want 1/0/0", ls_done, if_done, mem_wr); end
        ls_valid = 1'b0;
        step();
        n_cmp++; if (mem_a !== 32'h1000 || ls_done !== 1'b0) begin n_err++; $display("FAIL prio_fetch_start: got a=%h ls_done=%b want 1000/0", mem_a, ls_done); end
        step(); step(); step(); step();
        n_cmp++; if (if_done !== 1'b1 || if_data !== 32'h00000513) begin n_err++; $display("FAIL prio_fetch_done: got done=%b data=%h want 1/00000513", if_done, if_data); end
        if_valid = 1'b0;
        step();
        n_cmp++; if ({wlog[3], wlog[2], wlog[1], wlog[0]} !== 32'hDEADBEEF) begin n_err++; $display("FAIL prio_ram: got %h want deadbeef", {wlog[3], wlog[2], wlog[1], wlog[0]}); end
    endtask

    task automatic test_io_stall();
        int wc0;
        wc0 = wr_count;
        io_buffer_full = 1'b1;
        ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h0003_0000; ls_len = LEN_BYTE; ls_wdata = 32'h00000041;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 32'd0 || ls_done !== 1'b0) begin n_err++; $display("FAIL io_stall k=%0d: got wr=%b a=%h done=%b want 0/0/0", k, mem_wr, mem_a, ls_done); end
        end
        io_buffer_full = 1'b0;
        step();
        n_cmp++; if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h41) begin n_err++; $display("FAIL io_write: got wr=%b a=%h d=%h want 1/30000/41", mem_wr, mem_a, mem_dout); end
        step();
        n_cmp++; if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL io_done: got done=%b wr=%b want 1/0", ls_done, mem_wr); end
        ls_valid = 1'b0;
        step();
        n_cmp++; if (wr_count - wc0 !== 1 || last_wd !== 8'h41 || last_wa !== 32'h0003_0000) begin n_err++; $display("FAIL io_count: got n=%0d a=%h d=%h want 1/30000/41", wr_count - wc0, last_wa, last_wd); end
    endtask

    task automatic test_rdy_drop();
        logic [31:0] exp_a [0:6];
        exp_a[0] = 32'h100; exp_a[1] = 32'h101; exp_a[2] = 32'h101; exp_a[3] = 32'h101;
        exp_a[4] = 32'h101; exp_a[5] = 32'h102; exp_a[6] = 32'h103;
        ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_len = LEN_WORD;
        for (int k = 0; k < 7; k++) begin
            step();
            n_cmp++; if (mem_a !== exp_a[k] || ls_done !== 1'b0) begin n_err++; $display("FAIL rdy_addr k=%0d: got a=%h done=%b want %h/0", k, mem_a, ls_done, exp_a[k]); end
            rdy_in = (k == 1 || k == 2) ? 1'b0 : 1'b1;
        end
        step();
        n_cmp++; if (ls_done !== 1'b1 || ls_rdata !== 32'h44332211) begin n_err++; $display("FAIL rdy_data: got done=%b data=%h want 1/44332211", ls_done, ls_rdata); end
        ls_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int wc0;
        ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2000; ls_len = LEN_WORD; ls_wdata = 32'h01020304;
        step();
        n_cmp++; if (mem_wr !== 1'b1 || mem_dout !== 8'h04) begin n_err++; $display("FAIL rmid_b0: got wr=%b d=%h want 1/04", mem_wr, mem_dout); end
        step();
        n_cmp++; if (mem_a !== 32'h2001 || mem_dout !== 8'h03) begin n_err++; $display("FAIL rmid_b1: got a=%h d=%h want 2001/03", mem_a, mem_dout); end
        rst_in = 1'b1;
        step();
        n_cmp++;
        if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0 || ls_done !== 1'b0 || if_done !== 1'b0 || ls_rdata !== 32'd0 || if_data !== 32'd0) begin
            n_err++; $display("FAIL rmid_clear: got a=%h wr=%b d=%h lsd=%b ifd=%b want all 0", mem_a, mem_wr, mem_dout, ls_done, if_done);
        end
        rst_in = 1'b0;
        ls_valid = 1'b0;
        wc0 = wr_count;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (mem_wr !== 1'b0 || ls_done !== 1'b0) begin n_err++; $display("FAIL rmid_quiet k=%0d: got wr=%b done=%b want 0/0", k, mem_wr, ls_done); end
        end
        n_cmp++; if (wr_count !== wc0) begin n_err++; $display("FAIL rmid_writes: got %0d want %0d", wr_count, wc0); end
        ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_len = LEN_BYTE;
        step();
        n_cmp++; if (mem_a !== 32'h100) begin n_err++; $display("FAIL rmid_new_addr: got %h want 100", mem_a); end
        step();
        n_cmp++; if (ls_done !== 1'b1 || ls_rdata !== 32'h00000011) begin n_err++; $display("FAIL rmid_new_data: got done=%b data=%h want 1/00000011", ls_done, ls_rdata); end
        ls_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_valid = 1'b0; if_addr = 32'd0;
        ls_valid = 1'b0; ls_wr = 1'b0; ls_addr = 32'd0; ls_len = LEN_BYTE; ls_wdata = 32'd0;
        test_reset();
        test_fetch();
        test_load_half();
        test_priority();
        test_io_stall();
        test_rdy_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
